// File: rtl/mhd_pkg.sv
// Shared types and constants for the Hamming-distance stream monitor.
// Holds the FSM state encoding and the helper that sizes HD values.
package mhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WIDTH_D = 18;
  localparam int MHD_D   = 4;

  // Bits needed to hold any distance from 0 up to and including w.
  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/hd_popcount.sv
// Combinational Hamming distance between two words: popcount(a ^ b).
// The result is sized so that both 0 and WIDTH are representable.
module hd_popcount
  import mhd_pkg::*;
#(
  parameter  int WIDTH = WIDTH_D,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [HD_W-1:0]  hd
);

  logic [WIDTH-1:0] diff;

  always_comb begin
    diff = a ^ b;
    hd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd = hd + HD_W'(diff[i]);
    end
  end

endmodule

// File: rtl/mhd_stream_monitor.sv
// Streams exact/approximate word pairs, flags pairs whose Hamming distance
// exceeds MHD, and reports run statistics once N pairs have been checked.
module mhd_stream_monitor
  import mhd_pkg::*;
#(
  parameter  int WIDTH = WIDTH_D,
  parameter  int MHD   = MHD_D,
  parameter  int CNT_W = 16,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic             first_viol_vld,
  output logic [CNT_W-1:0] first_viol_idx
);

  localparam logic [HD_W-1:0] MHD_L = HD_W'(MHD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic             s1_vld_q, s1_vld_d;
  logic [HD_W-1:0]  s1_hd_q, s1_hd_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic             s2_vld_q, s2_vld_d;
  logic [HD_W-1:0]  s2_hd_q, s2_hd_d;
  logic [CNT_W-1:0] s2_idx_q, s2_idx_d;

  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [HD_W-1:0]  max_hd_q, max_hd_d;
  logic             fv_vld_q, fv_vld_d;
  logic [CNT_W-1:0] fv_idx_q, fv_idx_d;

  logic [HD_W-1:0]  hd_in;
  logic             xfer;
  logic             start_ok;
  logic             s2_viol;

  hd_popcount #(.WIDTH(WIDTH)) u_hd_popcount (
    .a  (in_a),
    .b  (in_b),
    .hd (hd_in)
  );

  assign in_ready       = (state_q == RUN) && (acc_q < n_q);
  assign xfer           = in_valid && in_ready;
  assign start_ok       = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = done && (viol_cnt_q == '0);
  assign viol_cnt       = viol_cnt_q;
  assign max_hd         = max_hd_q;
  assign first_viol_vld = fv_vld_q;
  assign first_viol_idx = fv_idx_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = num_samples;
          acc_d   = '0;
          state_d = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Done only once the last sample has left both pipeline stages.
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d = xfer;
    s1_hd_d  = hd_in;
    s1_idx_d = acc_q;
    s2_vld_d = s1_vld_q;
    s2_hd_d  = s1_hd_q;
    s2_idx_d = s1_idx_q;
  end

  always_comb begin
    viol_cnt_d = viol_cnt_q;
    max_hd_d   = max_hd_q;
    fv_vld_d   = fv_vld_q;
    fv_idx_d   = fv_idx_q;
    s2_viol    = s2_vld_q && (s2_hd_q > MHD_L);
    if (start_ok) begin
      viol_cnt_d = '0;
      max_hd_d   = '0;
      fv_vld_d   = 1'b0;
      fv_idx_d   = '0;
    end else if (s2_vld_q) begin
      if (s2_viol) begin
        viol_cnt_d = viol_cnt_q + 1'b1;
        if (!fv_vld_q) begin
          fv_vld_d = 1'b1;
          fv_idx_d = s2_idx_q;
        end
      end
      if (s2_hd_q > max_hd_q) max_hd_d = s2_hd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_hd_q    <= '0;
      s1_idx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_hd_q    <= '0;
      s2_idx_q   <= '0;
      viol_cnt_q <= '0;
      max_hd_q   <= '0;
      fv_vld_q   <= 1'b0;
      fv_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      s1_vld_q   <= s1_vld_d;
      s1_hd_q    <= s1_hd_d;
      s1_idx_q   <= s1_idx_d;
      s2_vld_q   <= s2_vld_d;
      s2_hd_q    <= s2_hd_d;
      s2_idx_q   <= s2_idx_d;
      viol_cnt_q <= viol_cnt_d;
      max_hd_q   <= max_hd_d;
      fv_vld_q   <= fv_vld_d;
      fv_idx_q   <= fv_idx_d;
    end
  end

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// Randomized scoreboard bench for mhd_stream_monitor: each run's expected
// statistics are queued at stimulus time and checked when done rises.
module tb_mhd_stream_monitor;

  localparam int WIDTH = 18;
  localparam int MHD   = 4;
  localparam int CNT_W = 16;
  localparam int HD_W  = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] viol_cnt;
  logic [HD_W-1:0]  max_hd;
  logic             first_viol_vld;
  logic [CNT_W-1:0] first_viol_idx;

  typedef struct {
    int viol;
    int mx;
    bit fvv;
    int fvi;
    bit pass;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hd_list[16];
  int   checks = 0;
  int   errors = 0;
  bit   done_seen = 1'b0;

  mhd_stream_monitor #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_samples    (num_samples),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .viol_cnt       (viol_cnt),
    .max_hd         (max_hd),
    .first_viol_vld (first_viol_vld),
    .first_viol_idx (first_viol_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string name);
    check_output(name, longint'({in_ready, busy, done, pass, viol_cnt, max_hd,
                                  first_viol_vld, first_viol_idx}), 0);
  endtask

  task automatic make_pair(input int hd, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] mask;
    mask = '0;
    while ($countones(mask) < hd) mask[$urandom_range(WIDTH-1, 0)] = 1'b1;
    a = WIDTH'($urandom);
    b = a ^ mask;
  endtask

  // Pulses start for one cycle, then checks that statistics were cleared.
  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start       = 1'b0;
    num_samples = CNT_W'($urandom);
    @(negedge clk);
    check_output("clear_viol_cnt", viol_cnt, 0);
    check_output("clear_max_hd", max_hd, 0);
    check_output("clear_first_viol_vld", first_viol_vld, 0);
    check_output("start_done", done, (n == 0) ? 1 : 0);
    check_output("start_pass", pass, (n == 0) ? 1 : 0);
    check_output("start_busy", busy, (n == 0) ? 0 : 1);
    @(posedge clk); #1;
  endtask

  // vmode: 0 valid held high, 1 valid every other cycle, 2 random valid.
  task automatic apply_stimulus(input int n, input int vmode, input bit mid_start, input int rst_after);
    exp_t             e;
    int               sent;
    int               cyc;
    int               k;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    e = '{viol: 0, mx: 0, fvv: 1'b0, fvi: 0, pass: 1'b1};
    for (int i = 0; i < n; i++) begin
      if (hd_list[i] > MHD) begin
        if (!e.fvv) begin
          e.fvv = 1'b1;
          e.fvi = i;
        end
        e.viol++;
      end
      if (hd_list[i] > e.mx) e.mx = hd_list[i];
    end
    e.pass = (e.viol == 0);
    if (rst_after < 0) exp_q.push_back(e);
    do_start(n);
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 200) begin
      make_pair(hd_list[sent], a, b);
      in_a = a;
      in_b = b;
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((cyc % 2) == 0);
        default: in_valid = ($urandom_range(2, 0) != 0);
      endcase
      if (mid_start && cyc == 1) begin
        start       = 1'b1;
        num_samples = CNT_W'(n + 3);
      end
      @(negedge clk);
      check_output("in_ready_open", in_ready, 1);
      check_output("busy_run", busy, 1);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      start       = 1'b0;
      num_samples = CNT_W'($urandom);
      in_valid    = 1'b0;
      cyc++;
      if (rst_after >= 0 && sent == rst_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_run");
        @(posedge clk); #1;
        return;
      end
    end
    check_output("transfer_count", sent, n);
    if (n > 0) begin
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (k == 0) check_output("in_ready_closed", in_ready, 0);
        if (done) break;
      end
      check_output("done_latency", k, 3);
    end else begin
      repeat (2) begin
        @(negedge clk);
        check_output("in_ready_n0", in_ready, 0);
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares the queued expectation whenever a run completes.
  always @(negedge clk) begin
    if (done && !done_seen) begin
      check_output("expected_pending", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_output("viol_cnt", viol_cnt, mon_e.viol);
        check_output("max_hd", max_hd, mon_e.mx);
        check_output("first_viol_vld", first_viol_vld, mon_e.fvv);
        if (mon_e.fvv) check_output("first_viol_idx", first_viol_idx, mon_e.fvi);
        check_output("pass", pass, mon_e.pass);
      end
    end
    done_seen = done;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk); #1;

    hd_list[0] = 0; hd_list[1] = 4; hd_list[2] = 5; hd_list[3] = 18;
    apply_stimulus(4, 0, 1'b0, -1);

    hd_list[0] = 1; hd_list[1] = 2; hd_list[2] = 4;
    apply_stimulus(3, 1, 1'b0, -1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_after_done");
    @(posedge clk); #1;
    apply_stimulus(0, 0, 1'b0, -1);

    for (int i = 0; i < 5; i++) hd_list[i] = $urandom_range(WIDTH, 0);
    apply_stimulus(5, 0, 1'b0, 2);
    hd_list[0] = 7;
    apply_stimulus(1, 0, 1'b0, -1);

    for (int i = 0; i < 4; i++) hd_list[i] = $urandom_range(6, 2);
    apply_stimulus(4, 0, 1'b1, -1);

    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        hd_list[i] = ($urandom_range(1, 0) == 0) ? $urandom_range(MHD + 2, MHD - 2)
                                                 : $urandom_range(WIDTH, 0);
      end
      apply_stimulus(n, $urandom_range(2, 0), ($urandom_range(3, 0) == 0), -1);
    end

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mhd_stream_monitor.md
Name: mhd_stream_monitor

Overview:
- Sequential Hamming-distance error monitor, placed directly downstream of an exact/approximate circuit pair.
- Accepts a stream of output-word pairs (exact vs approximate) through a valid/ready handshake.
- For each pair, computes the Hamming distance (HD) and flags it when HD > MHD.
- Over a run of N samples, accumulates violation count, maximum HD and index of the first violation; reports pass/fail at the end.

Parameters:
- WIDTH, 18, bit width of each compared word.
- MHD, 4, maximum tolerated Hamming distance; a sample violates when HD > MHD (strict).
- CNT_W, 16, width of sample-count and index fields.
- HD_W, $clog2(WIDTH+1) (5 for WIDTH=18), width of HD values; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- num_samples  input  CNT_W  N, number of pairs in the run; sampled on the start cycle.
- in_valid  input  1  pair on in_a/in_b is valid.
- in_ready  output  1  monitor accepts a pair this cycle.
- in_a  input  WIDTH  exact output word.
- in_b  input  WIDTH  approximate output word.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  run complete; statistics are final.
- pass  output  1  done && viol_cnt==0.
- viol_cnt  output  CNT_W  number of samples with HD > MHD.
- max_hd  output  HD_W  largest HD seen in the run.
- first_viol_vld  output  1  at least one violation recorded.
- first_viol_idx  output  CNT_W  0-based index of the first violating sample.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0, including in_ready, busy, done, pass and all statistics. Reset overrides everything, including mid-run; any in-flight pipeline data is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear all statistics and the accept/index counters, latch N, drop done.
  - N==0: go to DONE next cycle; done=1, pass=1.
  - Otherwise go to RUN.
- RUN:
  - in_ready = (accepted < N).
  - A transfer occurs on in_valid && in_ready; each transfer increments the accept counter.
  - in_valid with in_ready=0 is ignored (no transfer).
  - The cycle of the N-th transfer moves the FSM to DRAIN. in_ready is 0 from the following cycle.
- Pipeline, two registered stages:
  - S1: hd = popcount(in_a ^ in_b), computed in HD_W bits; sample index and a valid bit registered with it.
  - S2: if valid, update statistics:
    - viol = hd > MHD; viol_cnt += viol.
    - max_hd = max(max_hd, hd).
    - On the first viol, capture first_viol_idx and set first_viol_vld.
  - Latency: a pair transferred at edge t is reflected in the statistics outputs after edge t+2.
- DRAIN: wait until both pipeline valid bits are 0, then go to DONE. done rises the cycle after the final statistics update.
- DONE: done=1 and statistics held stable until the next start or rst. pass = (viol_cnt==0).
- start in RUN or DRAIN is ignored; num_samples is ignored outside the start cycle.
- Counter ranges: viol_cnt ≤ N < 2^CNT_W, so viol_cnt cannot overflow. The index counter never exceeds N-1.
- HD boundaries: HD=0 and HD=WIDTH must both be representable; HD==MHD is not a violation.

Decomposition:
- Shared package mhd_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function hd_width(w) = $clog2(w+1);
  - default constants WIDTH_D=18, MHD_D=4.
- One sub-module, hd_popcount: parameterized combinational popcount(a^b) of WIDTH bits, giving an HD_W-bit result, instantiated in S1.

Test Plan:
- N=4, pairs with HD 0, 4, 5, 18, in_valid held high -> done; viol_cnt=2, max_hd=18, first_viol_idx=2, first_viol_vld=1, pass=0; done rises 4 cycles after the last transfer edge at most.
- N=3, HD 1, 2, 4, in_valid toggling every other cycle -> exactly 3 transfers, in_ready drops after the 3rd; viol_cnt=0, max_hd=4, pass=1, first_viol_vld=0.
- start with num_samples=0 -> done=1 and pass=1 one cycle later; in_ready never asserted.
- N=5, rst pulsed after the 2nd transfer -> all outputs 0, state IDLE; a new start with N=1 and HD 7 -> viol_cnt=1, first_viol_idx=0.
- start pulsed during RUN with a different num_samples -> ignored; the run completes using the original N.
- Back-to-back runs: second start while in DONE -> statistics clear the cycle after start; second run's results are independent of the first.
